// File: rtl/joint_stepper_bank.sv
// joint_stepper_bank: N-channel step/dir generator with clamped period,
// DIR setup timing, DIR inversion; JOINT_STEPPER_BANK_LATCH_EN adds fb_latch.
module joint_stepper_bank #(
    parameter int unsigned         CHANNELS          = 5,
    parameter int unsigned         STEP_PULSE_CYCLES = 96,
    parameter int unsigned         DIR_SETUP_CYCLES  = 96,
    parameter logic [CHANNELS-1:0] DIR_INVERT        = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    disabled,
    input  logic [CHANNELS-1:0]     jointEnable,
    input  logic [32*CHANNELS-1:0]  jointFreqCmd,
    output logic [32*CHANNELS-1:0]  jointFeedback,
    output logic [CHANNELS-1:0]     STP,
    output logic [CHANNELS-1:0]     DIR
`ifdef JOINT_STEPPER_BANK_LATCH_EN
    ,
    input  logic                    fb_latch
`endif
);

    localparam logic [31:0] MIN_PER = 32'(2 * STEP_PULSE_CYCLES);
    localparam logic [31:0] PW_LOAD = 32'(STEP_PULSE_CYCLES - 1);
    localparam logic [31:0] SU_LOAD = 32'(DIR_SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_PULSE
    } state_t;

    logic [CHANNELS-1:0][31:0] pos_live;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [31:0] cmd_u;
        logic [31:0] mag;
        logic [31:0] p_eff;
        logic        go;
        logic        cmd_dir;
        state_t      st_q;
        state_t      st_n;
        logic        dir_q;
        logic        dir_n;
        logic        stp_q;
        logic        stp_n;
        logic [31:0] per_q;
        logic [31:0] per_n;
        logic [31:0] su_q;
        logic [31:0] su_n;
        logic [31:0] pw_q;
        logic [31:0] pw_n;
        logic [31:0] pos_q;
        logic [31:0] pos_n;

        // command decode: run request, wanted direction, clamped period
        always_comb begin
            cmd_u   = jointFreqCmd[32*i +: 32];
            go      = jointEnable[i] && !disabled && (cmd_u != '0);
            cmd_dir = !cmd_u[31] && (cmd_u != '0);
            if (cmd_u == 32'h8000_0000) begin
                mag = 32'h7fff_ffff;
            end else if (cmd_u[31]) begin
                mag = ~cmd_u + 32'd1;
            end else begin
                mag = cmd_u;
            end
            p_eff = (mag < MIN_PER) ? MIN_PER : mag;
        end

        // next-state: pulses are never cut short, DIR only moves outside them
        always_comb begin
            st_n  = st_q;
            dir_n = dir_q;
            stp_n = stp_q;
            per_n = per_q;
            su_n  = su_q;
            pw_n  = pw_q;
            pos_n = pos_q;
            unique case (st_q)
                S_IDLE: begin
                    if (go) begin
                        if (cmd_dir == dir_q) begin
                            st_n  = S_WAIT;
                            per_n = '0;
                        end else begin
                            dir_n = cmd_dir;
                            su_n  = SU_LOAD;
                            st_n  = S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (!go) begin
                        st_n = S_IDLE;
                    end else if (su_q == '0) begin
                        st_n  = S_WAIT;
                        per_n = '0;
                    end else begin
                        su_n = su_q - 32'd1;
                    end
                end
                S_WAIT: begin
                    per_n = per_q + 32'd1;
                    if (!go) begin
                        st_n = S_IDLE;
                    end else if (cmd_dir != dir_q) begin
                        dir_n = cmd_dir;
                        su_n  = SU_LOAD;
                        st_n  = S_SETUP;
                    end else if (per_q >= p_eff - 32'd1) begin
                        stp_n = 1'b1;
                        pos_n = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                        per_n = '0;
                        pw_n  = PW_LOAD;
                        st_n  = S_PULSE;
                    end
                end
                S_PULSE: begin
                    per_n = per_q + 32'd1;
                    if (pw_q == '0) begin
                        stp_n = 1'b0;
                        st_n  = go ? S_WAIT : S_IDLE;
                    end else begin
                        pw_n = pw_q - 32'd1;
                    end
                end
                default: begin
                    st_n = S_IDLE;
                end
            endcase
        end

        // channel registers, synchronous reset may cut a pulse short
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st_q  <= S_IDLE;
                dir_q <= 1'b0;
                stp_q <= 1'b0;
                per_q <= '0;
                su_q  <= '0;
                pw_q  <= '0;
                pos_q <= '0;
            end else begin
                st_q  <= st_n;
                dir_q <= dir_n;
                stp_q <= stp_n;
                per_q <= per_n;
                su_q  <= su_n;
                pw_q  <= pw_n;
                pos_q <= pos_n;
            end
        end

        assign STP[i]      = stp_q;
        assign DIR[i]      = dir_q ^ DIR_INVERT[i];
        assign pos_live[i] = pos_q;
    end

`ifdef JOINT_STEPPER_BANK_LATCH_EN
    logic [CHANNELS-1:0][31:0] snap_q;

    // capture every channel on the same edge so the host sees one instant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (fb_latch) begin
            snap_q <= pos_live;
        end
    end

    assign jointFeedback = snap_q;
`else
    assign jointFeedback = pos_live;
`endif

endmodule
